// File: rtl/seq_detector.sv
// Serial pattern detector: KMP prefix automaton over a gated bit stream with a
// registered match pulse, selectable overlap and a saturating match counter.
module seq_detector #(
    parameter int              PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit              OVERLAP = 1'b1,
    parameter int              COUNT_W = 8,
    localparam int             LW      = ($clog2(PAT_W) < 1) ? 1 : $clog2(PAT_W)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               In_valid,
    input  logic               In1,
    input  logic               Clr,
    output logic               Out1,
    output logic [LW-1:0]      Prefix_len,
    output logic [COUNT_W-1:0] Match_cnt
);

    logic               out1_r;
    logic [LW-1:0]      len_r;
    logic [COUNT_W-1:0] cnt_r;
    logic [LW:0]        step_s;
    logic               match_s;
    logic [LW-1:0]      nlen_s;
    logic [LW-1:0]      load_len_s;

    // Returns {full_match, longest proper pattern prefix that is a suffix of
    // prefix(l) followed by b}. On a full match the length field is the
    // longest proper border of the pattern, which is the overlap restart point.
    function automatic logic [LW:0] step_fn(input logic [LW-1:0] l, input logic b);
        int   best;
        int   lv;
        int   idx;
        logic hit;
        logic cbit;
        logic full;
        best = 0;
        full = 1'b0;
        lv   = int'(l);
        for (int k = 1; k <= PAT_W; k++) begin
            if (k <= lv + 1) begin
                hit = 1'b1;
                for (int j = 0; j < PAT_W; j++) begin
                    if (j < k) begin
                        idx  = lv + 1 - k + j;
                        cbit = (idx == lv) ? b : PATTERN[PAT_W-1-idx];
                        if (cbit != PATTERN[PAT_W-1-j]) begin
                            hit = 1'b0;
                        end else begin
                            hit = hit;
                        end
                    end else begin
                        hit = hit;
                    end
                end
                if (hit) begin
                    if (k == PAT_W) begin
                        full = 1'b1;
                    end else begin
                        best = k;
                    end
                end else begin
                    best = best;
                end
            end else begin
                best = best;
            end
        end
        return {full, LW'(best)};
    endfunction

    // Next-state evaluation for the current prefix length and incoming bit.
    always_comb begin
        step_s  = step_fn(len_r, In1);
        match_s = step_s[LW];
        nlen_s  = step_s[LW-1:0];
        if (match_s && !OVERLAP) begin
            load_len_s = {LW{1'b0}};
        end else begin
            load_len_s = nlen_s;
        end
    end

    // Automaton state, match pulse and saturating counter; Clr beats a valid bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out1_r <= 1'b0;
            len_r  <= {LW{1'b0}};
            cnt_r  <= {COUNT_W{1'b0}};
        end else if (Clr) begin
            out1_r <= 1'b0;
            len_r  <= {LW{1'b0}};
            cnt_r  <= {COUNT_W{1'b0}};
        end else if (In_valid) begin
            out1_r <= match_s;
            len_r  <= load_len_s;
            if (match_s && (cnt_r != {COUNT_W{1'b1}})) begin
                cnt_r <= cnt_r + COUNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            out1_r <= 1'b0;
            len_r  <= len_r;
            cnt_r  <= cnt_r;
        end
    end

    assign Out1       = out1_r;
    assign Prefix_len = len_r;
    assign Match_cnt  = cnt_r;

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector: several parameterisations share one stimulus
// stream, each scenario task checks its own hand-computed expectations.
module tb_seq_detector;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic In_valid = 1'b0;
    logic In1 = 1'b0;
    logic Clr = 1'b0;

    logic       out_a, out_e, out_b, out_c, out_d;
    logic [1:0] len_a, len_e, len_b, len_c, len_d;
    logic [7:0] cnt_a, cnt_e, cnt_b, cnt_c;
    logic [1:0] cnt_d;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    seq_detector u_a (.CLK(CLK), .RST(RST), .In_valid(In_valid), .In1(In1), .Clr(Clr),
                      .Out1(out_a), .Prefix_len(len_a), .Match_cnt(cnt_a));
    seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .COUNT_W(8)) u_e (
                      .CLK(CLK), .RST(RST), .In_valid(In_valid), .In1(In1), .Clr(Clr),
                      .Out1(out_e), .Prefix_len(len_e), .Match_cnt(cnt_e));
    seq_detector #(.PAT_W(4), .PATTERN(4'b0000), .OVERLAP(1'b1), .COUNT_W(8)) u_b (
                      .CLK(CLK), .RST(RST), .In_valid(In_valid), .In1(In1), .Clr(Clr),
                      .Out1(out_b), .Prefix_len(len_b), .Match_cnt(cnt_b));
    seq_detector #(.PAT_W(4), .PATTERN(4'b0000), .OVERLAP(1'b0), .COUNT_W(8)) u_c (
                      .CLK(CLK), .RST(RST), .In_valid(In_valid), .In1(In1), .Clr(Clr),
                      .Out1(out_c), .Prefix_len(len_c), .Match_cnt(cnt_c));
    seq_detector #(.PAT_W(4), .PATTERN(4'b0000), .OVERLAP(1'b1), .COUNT_W(2)) u_d (
                      .CLK(CLK), .RST(RST), .In_valid(In_valid), .In1(In1), .Clr(Clr),
                      .Out1(out_d), .Prefix_len(len_d), .Match_cnt(cnt_d));

    // Apply one edge of stimulus; returns 1 ns after the edge.
    task automatic step(input logic v, input logic b, input logic c);
        In_valid = v;
        In1      = b;
        Clr      = c;
        @(posedge CLK);
        #1;
        In_valid = 1'b0;
        Clr      = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        @(posedge CLK);
        #3;
        RST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] bits;
        bits = 4'b1011;
        @(posedge CLK);
        #1;
        n_cmp++; if (out_a !== 1'b0) begin n_err++; $display("FAIL reset_out1 got %b want 0", out_a); end
        n_cmp++; if (len_a !== 2'd0) begin n_err++; $display("FAIL reset_len got %0d want 0", len_a); end
        n_cmp++; if (cnt_a !== 8'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", cnt_a); end
        #2 RST = 1'b1;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, bits[3-i], 1'b0);
            n_cmp++;
            if (out_a !== (i == 3)) begin
                n_err++; $display("FAIL basic_out1[%0d] got %b want %b", i, out_a, (i == 3));
            end
        end
        n_cmp++; if (cnt_a !== 8'd1) begin n_err++; $display("FAIL basic_cnt got %0d want 1", cnt_a); end
        n_cmp++; if (len_a !== 2'd1) begin n_err++; $display("FAIL basic_len got %0d want 1", len_a); end
        #3 RST = 1'b0;
        #1;
        n_cmp++; if (out_a !== 1'b0) begin n_err++; $display("FAIL midreset_out1 got %b want 0", out_a); end
        n_cmp++; if (len_a !== 2'd0) begin n_err++; $display("FAIL midreset_len got %0d want 0", len_a); end
        n_cmp++; if (cnt_a !== 8'd0) begin n_err++; $display("FAIL midreset_cnt got %0d want 0", cnt_a); end
        #3 RST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_overlap_1011();
        logic [6:0] bits;
        int la[7] = '{1, 2, 3, 1, 2, 3, 1};
        int le[7] = '{1, 2, 3, 0, 0, 1, 1};
        logic [6:0] oa;
        logic [6:0] oe;
        bits = 7'b1011011;
        oa   = 7'b0001001;
        oe   = 7'b0001000;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, bits[6-i], 1'b0);
            n_cmp++; if (len_a !== 2'(la[i])) begin n_err++; $display("FAIL ov_len[%0d] got %0d want %0d", i, len_a, la[i]); end
            n_cmp++; if (len_e !== 2'(le[i])) begin n_err++; $display("FAIL nov_len[%0d] got %0d want %0d", i, len_e, le[i]); end
            n_cmp++; if (out_a !== oa[6-i]) begin n_err++; $display("FAIL ov_out1[%0d] got %b want %b", i, out_a, oa[6-i]); end
            n_cmp++; if (out_e !== oe[6-i]) begin n_err++; $display("FAIL nov_out1[%0d] got %b want %b", i, out_e, oe[6-i]); end
        end
        n_cmp++; if (cnt_a !== 8'd2) begin n_err++; $display("FAIL ov_cnt got %0d want 2", cnt_a); end
        n_cmp++; if (cnt_e !== 8'd1) begin n_err++; $display("FAIL nov_cnt got %0d want 1", cnt_e); end
    endtask

    task automatic test_overlap_zero();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b0);
            n_cmp++; if (out_b !== (i >= 3)) begin n_err++; $display("FAIL z_ov_out1[%0d] got %b want %b", i, out_b, (i >= 3)); end
            n_cmp++; if (out_c !== (i == 3 || i == 7)) begin
                n_err++; $display("FAIL z_nov_out1[%0d] got %b want %b", i, out_c, (i == 3 || i == 7));
            end
        end
        n_cmp++; if (cnt_b !== 8'd5) begin n_err++; $display("FAIL z_ov_cnt got %0d want 5", cnt_b); end
        n_cmp++; if (cnt_c !== 8'd2) begin n_err++; $display("FAIL z_nov_cnt got %0d want 2", cnt_c); end
        n_cmp++; if (len_b !== 2'd3) begin n_err++; $display("FAIL z_ov_len got %0d want 3", len_b); end
        n_cmp++; if (len_c !== 2'd0) begin n_err++; $display("FAIL z_nov_len got %0d want 0", len_c); end
    endtask

    task automatic test_gapped();
        logic [3:0] bits;
        int la[4] = '{1, 2, 3, 1};
        bits = 4'b1011;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, bits[3-i], 1'b0);
            n_cmp++; if (out_a !== (i == 3)) begin n_err++; $display("FAIL gap_out1[%0d] got %b want %b", i, out_a, (i == 3)); end
            n_cmp++; if (len_a !== 2'(la[i])) begin n_err++; $display("FAIL gap_len[%0d] got %0d want %0d", i, len_a, la[i]); end
            if (i < 3) begin
                for (int g = 0; g < 3; g++) begin
                    step(1'b0, ~bits[3-i] ^ g[0], 1'b0);
                    n_cmp++; if (out_a !== 1'b0) begin n_err++; $display("FAIL gap_idle_out1[%0d.%0d] got %b want 0", i, g, out_a); end
                    n_cmp++; if (len_a !== 2'(la[i])) begin
                        n_err++; $display("FAIL gap_idle_len[%0d.%0d] got %0d want %0d", i, g, len_a, la[i]);
                    end
                end
            end
        end
        step(1'b0, 1'b1, 1'b0);
        n_cmp++; if (out_a !== 1'b0) begin n_err++; $display("FAIL gap_after_out1 got %b want 0", out_a); end
        n_cmp++; if (cnt_a !== 8'd1) begin n_err++; $display("FAIL gap_cnt got %0d want 1", cnt_a); end
    endtask

    task automatic test_clear();
        logic [3:0] bits;
        bits = 4'b1011;
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        n_cmp++; if (len_a !== 2'd0) begin n_err++; $display("FAIL clr_len got %0d want 0", len_a); end
        n_cmp++; if (out_a !== 1'b0) begin n_err++; $display("FAIL clr_out1 got %b want 0", out_a); end
        n_cmp++; if (cnt_a !== 8'd0) begin n_err++; $display("FAIL clr_cnt got %0d want 0", cnt_a); end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, bits[3-i], 1'b0);
            n_cmp++; if (out_a !== (i == 3)) begin n_err++; $display("FAIL clr_rerun_out1[%0d] got %b want %b", i, out_a, (i == 3)); end
        end
        n_cmp++; if (cnt_a !== 8'd1) begin n_err++; $display("FAIL clr_rerun_cnt got %0d want 1", cnt_a); end
    endtask

    task automatic test_saturation();
        int pulses;
        int exp_cnt;
        pulses = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (out_d === 1'b1) pulses++;
            exp_cnt = (i < 3) ? 0 : ((i - 2 > 3) ? 3 : i - 2);
            n_cmp++; if (out_d !== (i >= 3)) begin n_err++; $display("FAIL sat_out1[%0d] got %b want %b", i, out_d, (i >= 3)); end
            n_cmp++; if (cnt_d !== 2'(exp_cnt)) begin n_err++; $display("FAIL sat_cnt[%0d] got %0d want %0d", i, cnt_d, exp_cnt); end
        end
        n_cmp++; if (pulses != 7) begin n_err++; $display("FAIL sat_pulses got %0d want 7", pulses); end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        n_cmp++; if (len_a !== 2'd3) begin n_err++; $display("FAIL ar_pre_len got %0d want 3", len_a); end
        #3 RST = 1'b0;
        #2;
        n_cmp++; if (len_a !== 2'd0) begin n_err++; $display("FAIL ar_len got %0d want 0", len_a); end
        n_cmp++; if (out_a !== 1'b0) begin n_err++; $display("FAIL ar_out1 got %b want 0", out_a); end
        #3 RST = 1'b1;
        @(posedge CLK);
        #1;
        step(1'b1, 1'b1, 1'b0);
        n_cmp++; if (out_a !== 1'b0) begin n_err++; $display("FAIL ar_post_out1 got %b want 0", out_a); end
        n_cmp++; if (len_a !== 2'd1) begin n_err++; $display("FAIL ar_post_len got %0d want 1", len_a); end
        n_cmp++; if (cnt_a !== 8'd0) begin n_err++; $display("FAIL ar_post_cnt got %0d want 0", cnt_a); end
    endtask

    initial begin
        test_reset();
        test_overlap_1011();
        test_overlap_zero();
        test_gapped();
        test_clear();
        test_saturation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
